// File: rtl/clock_divider_hb_multi.sv
// rtl/clock_divider_hb_multi.sv - multi-channel programmable clock divider / heartbeat generator
module clock_divider_hb_multi #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 32,
  parameter int THRESHOLD = 50_000,
  parameter int ON_TIME   = 20_000,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_restart,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [WIDTH-1:0]    cfg_on_time,
  input  logic                cfg_oneshot,
  output logic [CHANNELS-1:0] dividedClk,
  output logic [CHANNELS-1:0] beat,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ch_state_e;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] THR_RST = (THRESHOLD == 0) ? WIDTH'(1) : WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] ON_RST  = WIDTH'(ON_TIME);

  ch_state_e                        state_q [CHANNELS];
  ch_state_e                        state_d [CHANNELS];
  logic [CHANNELS-1:0][WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   thr_s_q, thr_s_d, on_s_q, on_s_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   thr_a_q, thr_a_d, on_a_q, on_a_d;
  logic [CHANNELS-1:0]              os_s_q, os_s_d, os_a_q, os_a_d;
  logic [CHANNELS-1:0]              div_q, div_d, beat_q, beat_d;
  logic [CHANNELS-1:0]              busy_q, busy_d, done_q, done_d;

  // Per-channel next state: config capture, then enable/start/restart/wrap/count priority
  always_comb begin
    logic             wr_hit;
    logic [WIDTH-1:0] thr_n;
    logic [WIDTH-1:0] on_n;
    logic             os_n;
    wr_hit = 1'b0;
    thr_n  = '0;
    on_n   = '0;
    os_n   = 1'b0;
    cnt_d   = cnt_q;
    thr_s_d = thr_s_q;
    on_s_d  = on_s_q;
    os_s_d  = os_s_q;
    thr_a_d = thr_a_q;
    on_a_d  = on_a_q;
    os_a_d  = os_a_q;
    div_d   = div_q;
    beat_d  = beat_q;
    busy_d  = '0;
    done_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      // Shadow value as seen by a load on this same edge, so a write that
      // coincides with a wrap/start/restart is taken immediately.
      wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
      thr_n  = wr_hit ? ((cfg_threshold == '0) ? ONE : cfg_threshold) : thr_s_q[i];
      on_n   = wr_hit ? cfg_on_time : on_s_q[i];
      os_n   = wr_hit ? cfg_oneshot : os_s_q[i];
      thr_s_d[i] = thr_n;
      on_s_d[i]  = on_n;
      os_s_d[i]  = os_n;

      if (!enable[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        div_d[i]   = 1'b0;
        beat_d[i]  = 1'b0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_RUN;
            thr_a_d[i] = thr_n;
            on_a_d[i]  = on_n;
            os_a_d[i]  = os_n;
            cnt_d[i]   = '0;
            div_d[i]   = 1'b0;
            beat_d[i]  = (on_n != '0);
          end
          ST_RUN: begin
            if (sync_restart) begin
              thr_a_d[i] = thr_n;
              on_a_d[i]  = on_n;
              os_a_d[i]  = os_n;
              cnt_d[i]   = '0;
              div_d[i]   = 1'b0;
              beat_d[i]  = (on_n != '0);
            end else if (cnt_q[i] == thr_a_q[i] - ONE) begin
              cnt_d[i]   = '0;
              thr_a_d[i] = thr_n;
              on_a_d[i]  = on_n;
              os_a_d[i]  = os_n;
              if (os_a_q[i]) begin
                state_d[i] = ST_HALT;
                div_d[i]   = 1'b0;
                beat_d[i]  = 1'b0;
                done_d[i]  = 1'b1;
              end else begin
                div_d[i]  = ~div_q[i];
                beat_d[i] = (on_n != '0);
              end
            end else begin
              cnt_d[i]  = cnt_q[i] + ONE;
              beat_d[i] = ((cnt_q[i] + ONE) < on_a_q[i]);
            end
          end
          ST_HALT: begin
            cnt_d[i]  = '0;
            div_d[i]  = 1'b0;
            beat_d[i] = 1'b0;
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            div_d[i]   = 1'b0;
            beat_d[i]  = 1'b0;
          end
        endcase
      end
      busy_d[i] = (state_d[i] == ST_RUN);
    end
  end

  // State and output registers; reset returns every channel to idle with default config
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
      end
      cnt_q   <= '0;
      thr_s_q <= {CHANNELS{THR_RST}};
      on_s_q  <= {CHANNELS{ON_RST}};
      os_s_q  <= '0;
      thr_a_q <= {CHANNELS{THR_RST}};
      on_a_q  <= {CHANNELS{ON_RST}};
      os_a_q  <= '0;
      div_q   <= '0;
      beat_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q   <= cnt_d;
      thr_s_q <= thr_s_d;
      on_s_q  <= on_s_d;
      os_s_q  <= os_s_d;
      thr_a_q <= thr_a_d;
      on_a_q  <= on_a_d;
      os_a_q  <= os_a_d;
      div_q   <= div_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dividedClk = div_q;
  assign beat       = beat_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
